// File: rtl/register_file_sb_if.sv
// rtl/register_file_sb_if.sv - read, write-back, reservation and flush signals of the scoreboarded register file
interface register_file_sb_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] read_add_1;
   logic [ADDR_W-1:0] read_add_2;
   logic [DATA_W-1:0] read_data_1;
   logic [DATA_W-1:0] read_data_2;
   logic              read_busy_1;
   logic              read_busy_2;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_reg_add;
   logic [DATA_W-1:0] wr_data;
   logic              rsv_en;
   logic [ADDR_W-1:0] rsv_add;
   logic              rsv_ok;
   logic              clr_all;
   logic [ADDR_W:0]   busy_cnt;

   modport master (
      output read_add_1, read_add_2, wr_en, wr_reg_add, wr_data, rsv_en, rsv_add, clr_all,
      input  read_data_1, read_data_2, read_busy_1, read_busy_2, rsv_ok, busy_cnt
   );

   modport slave (
      input  read_add_1, read_add_2, wr_en, wr_reg_add, wr_data, rsv_en, rsv_add, clr_all,
      output read_data_1, read_data_2, read_busy_1, read_busy_2, rsv_ok, busy_cnt
   );
endinterface

// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - 2R/1W register file with per-register pending-write scoreboard
module register_file_sb #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input logic               clk,
   input logic               rst,
   register_file_sb_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;
   logic              wr_hit;
   logic              rsv_zero;
   logic              rsv_hit;

   function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
      return (ZERO_REG != 0) && (addr == '0);
   endfunction

   assign wr_hit      = bus.wr_en && !is_zero(bus.wr_reg_add);
   assign rsv_zero    = is_zero(bus.rsv_add);
   // busy is sampled pre-edge, so a register being written this cycle is still refused
   assign bus.rsv_ok  = rsv_zero | ~busy_q[bus.rsv_add] | bus.clr_all;
   assign rsv_hit     = bus.rsv_en && bus.rsv_ok && !rsv_zero;

   // Flush first, then write-back clears, then the new producer sets
   always_comb begin
      busy_d = bus.clr_all ? '0 : busy_q;
      if (wr_hit) begin
         busy_d[bus.wr_reg_add] = 1'b0;
      end
      if (rsv_hit) begin
         busy_d[bus.rsv_add] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else begin
         busy_q <= busy_d;
         if (wr_hit) begin
            regs[bus.wr_reg_add] <= bus.wr_data;
         end
      end
   end

   // Bypass is suppressed while reset is asserted so outputs read as cleared state
   always_comb begin
      bus.read_data_1 = regs[bus.read_add_1];
      bus.read_busy_1 = busy_q[bus.read_add_1];
      if (is_zero(bus.read_add_1)) begin
         bus.read_data_1 = '0;
         bus.read_busy_1 = 1'b0;
      end else if ((BYPASS != 0) && rst && bus.wr_en && (bus.wr_reg_add == bus.read_add_1)) begin
         bus.read_data_1 = bus.wr_data;
         bus.read_busy_1 = 1'b0;
      end
   end

   always_comb begin
      bus.read_data_2 = regs[bus.read_add_2];
      bus.read_busy_2 = busy_q[bus.read_add_2];
      if (is_zero(bus.read_add_2)) begin
         bus.read_data_2 = '0;
         bus.read_busy_2 = 1'b0;
      end else if ((BYPASS != 0) && rst && bus.wr_en && (bus.wr_reg_add == bus.read_add_2)) begin
         bus.read_data_2 = bus.wr_data;
         bus.read_busy_2 = 1'b0;
      end
   end

   always_comb begin
      bus.busy_cnt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         bus.busy_cnt = bus.busy_cnt + (ADDR_W + 1)'(busy_q[i]);
      end
   end
endmodule
